// File: rtl/touch_track_filter_pkg.sv
// touch_pkg: shared state encoding, sizing helper and default dimensions for the touch filter
package touch_pkg;

    typedef enum logic [1:0] {IDLE, ARMING, TRACK, RELEASING} state_e;

    localparam int DEF_ADC_W = 12;
    localparam int DEF_SCR_W = 800;
    localparam int DEF_SCR_H = 480;

    function automatic int pix_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/touch_track_filter_if.sv
// touch_track_filter_if: digitizer-side inputs and UI-side outputs of the touch filter
interface touch_track_filter_if #(
    parameter int ADC_W = touch_pkg::DEF_ADC_W,
    parameter int XW    = touch_pkg::pix_w(touch_pkg::DEF_SCR_W),
    parameter int YW    = touch_pkg::pix_w(touch_pkg::DEF_SCR_H),
    parameter int CNT_W = 10
);
    logic             iTouch;
    logic             iSample_valid;
    logic [ADC_W-1:0] iX_COORD;
    logic [ADC_W-1:0] iY_COORD;
    logic             iClearCount;
    logic             oValid;
    logic [XW-1:0]    oX_PIX;
    logic [YW-1:0]    oY_PIX;
    logic             oPress;
    logic             oRelease;
    logic             oHeld;
    logic [CNT_W-1:0] oPressCount;

    modport master (
        output iTouch, iSample_valid, iX_COORD, iY_COORD, iClearCount,
        input  oValid, oX_PIX, oY_PIX, oPress, oRelease, oHeld, oPressCount
    );

    modport slave (
        input  iTouch, iSample_valid, iX_COORD, iY_COORD, iClearCount,
        output oValid, oX_PIX, oY_PIX, oPress, oRelease, oHeld, oPressCount
    );
endinterface

// File: rtl/touch_track_filter_scaler.sv
// touch_scaler: optional inversion and fixed-point scale of an averaged ADC value to pixels, registered
module touch_scaler
    import touch_pkg::*;
#(
    parameter int ADC_W = DEF_ADC_W,
    parameter int SCR   = DEF_SCR_W,
    parameter int INV   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [ADC_W-1:0]       avg_i,
    output logic [pix_w(SCR)-1:0]  pix_o
);
    localparam int SW = pix_w(SCR);
    localparam int PW = ADC_W + SW;

    logic [ADC_W-1:0] v;
    logic [PW-1:0]    prod;
    logic [SW-1:0]    pix_q;

    // ~avg equals (2^ADC_W-1-avg); v*SCR < 2^ADC_W*SCR keeps the result in 0..SCR-1
    assign v    = (INV != 0) ? ~avg_i : avg_i;
    assign prod = PW'(v) * PW'(SCR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pix_q <= '0;
        else if (en_i) pix_q <= prod[PW-1:ADC_W];
    end

    assign pix_o = pix_q;
endmodule

// File: rtl/touch_track_filter.sv
// touch_track_filter: debounces pen-down, averages coordinate samples per report and scales them to
// LCD pixels, emitting press/release/valid strobes and a press counter.
module touch_track_filter
    import touch_pkg::*;
#(
    parameter int ADC_W    = DEF_ADC_W,
    parameter int SCR_W    = DEF_SCR_W,
    parameter int SCR_H    = DEF_SCR_H,
    parameter int AVG_LOG2 = 2,
    parameter int DEB_CYC  = 1024,
    parameter int INV_X    = 1,
    parameter int INV_Y    = 1,
    parameter int CNT_W    = 10
) (
    input logic iCLK,
    input logic iRST_n,
    touch_track_filter_if.slave bus
);
    localparam int AW = ADC_W + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
    localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    state_e           state_q, state_d;
    logic [DW-1:0]    deb_q, deb_d;
    logic [AW-1:0]    acc_x_q, acc_x_d, acc_y_q, acc_y_d, sum_x, sum_y;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ADC_W-1:0] avg_x_q, avg_y_q;
    logic             v1_q, v2_q;
    logic             held_q, held_d, rel_q, rel_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             touch, accept, last, press;

    assign touch  = sync_q[1];
    assign accept = (state_q == TRACK) && bus.iSample_valid;
    assign last   = (cnt_q == CNT_LAST);
    assign sum_x  = acc_x_q + AW'(bus.iX_COORD);
    assign sum_y  = acc_y_q + AW'(bus.iY_COORD);
    assign press  = v2_q && !held_q;

    // Release waits for in-flight blocks so a late first report still gets its matching oRelease
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        rel_d   = 1'b0;
        unique case (state_q)
            IDLE: if (touch) begin
                state_d = ARMING;
                deb_d   = DEB_LOAD;
            end
            ARMING: begin
                if (!touch) state_d = IDLE;
                else if (deb_q == '0) state_d = TRACK;
                else deb_d = deb_q - 1'b1;
            end
            TRACK: if (!touch) begin
                state_d = RELEASING;
                deb_d   = DEB_LOAD;
            end
            RELEASING: begin
                if (touch) state_d = TRACK;
                else if (deb_q != '0) deb_d = deb_q - 1'b1;
                else if (!v1_q && !v2_q) begin
                    state_d = IDLE;
                    rel_d   = held_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        cnt_d   = cnt_q;
        if (state_q != TRACK || !touch) begin
            acc_x_d = '0;
            acc_y_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            acc_x_d = last ? '0 : sum_x;
            acc_y_d = last ? '0 : sum_y;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        held_d = press ? 1'b1 : (rel_d ? 1'b0 : held_q);
        pcnt_d = bus.iClearCount ? CNT_W'(press) : pcnt_q + CNT_W'(press);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            deb_q   <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            cnt_q   <= '0;
            avg_x_q <= '0;
            avg_y_q <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            held_q  <= 1'b0;
            rel_q   <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], bus.iTouch};
            state_q <= state_d;
            deb_q   <= deb_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            cnt_q   <= cnt_d;
            v1_q    <= accept && last;
            v2_q    <= v1_q;
            held_q  <= held_d;
            rel_q   <= rel_d;
            pcnt_q  <= pcnt_d;
            if (accept && last) begin
                avg_x_q <= sum_x[AW-1:AVG_LOG2];
                avg_y_q <= sum_y[AW-1:AVG_LOG2];
            end
        end
    end

    touch_scaler #(.ADC_W(ADC_W), .SCR(SCR_W), .INV(INV_X)) u_scale_x (
        .clk_i  (iCLK),
        .rst_ni (iRST_n),
        .en_i   (v1_q),
        .avg_i  (avg_x_q),
        .pix_o  (bus.oX_PIX)
    );

    touch_scaler #(.ADC_W(ADC_W), .SCR(SCR_H), .INV(INV_Y)) u_scale_y (
        .clk_i  (iCLK),
        .rst_ni (iRST_n),
        .en_i   (v1_q),
        .avg_i  (avg_y_q),
        .pix_o  (bus.oY_PIX)
    );

    assign bus.oValid      = v2_q;
    assign bus.oPress      = press;
    assign bus.oRelease    = rel_q;
    assign bus.oHeld       = held_q;
    assign bus.oPressCount = pcnt_q;
endmodule

// File: tb/tb_touch_track_filter.sv
// tb_touch_track_filter: directed stimulus with a scoreboard of hand-computed reports
module tb_touch_track_filter;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   valid_ev = 0;
    int   press_ev = 0;
    int   rel_ev = 0;

    typedef struct {
        int x;
        int y;
        bit press;
        int due;
    } exp_t;

    exp_t sb[$];

    touch_track_filter_if #(.ADC_W(12), .XW(10), .YW(9), .CNT_W(10)) bus ();

    touch_track_filter #(.DEB_CYC(4)) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus.slave)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oPress) begin
                press_ev++;
                chk("press_with_valid", int'(bus.oValid), 1);
            end
            if (bus.oRelease) begin
                rel_ev++;
                chk("release_not_press", int'(bus.oPress), 0);
            end
            if (bus.oValid) begin
                valid_ev++;
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("x_pix", int'(bus.oX_PIX), e.x);
                    chk("y_pix", int'(bus.oY_PIX), e.y);
                    chk("press", int'(bus.oPress), int'(e.press));
                    chk("latency", cyc, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back samples; the report is due two cycles after the last one
    task automatic send_block(input int xb, input int xstep, input int y,
                              input int ex, input int ey, input bit ep, input bit clr);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.iSample_valid = 1'b1;
            bus.iX_COORD = 12'(xb + i * xstep);
            bus.iY_COORD = 12'(y);
            if (i == 3) sb.push_back('{ex, ey, ep, cyc + 2});
        end
        step();
        bus.iSample_valid = 1'b0;
        step();
        bus.iClearCount = clr;
        step();
        bus.iClearCount = 1'b0;
        step();
    endtask

    task automatic press_cycle(input bit clr);
        bus.iTouch = 1'b1;
        repeat (9) step();
        send_block(0, 0, 4095, 799, 0, 1'b1, clr);
        bus.iTouch = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.iTouch = 1'b0;
        bus.iSample_valid = 1'b0;
        bus.iX_COORD = '0;
        bus.iY_COORD = '0;
        bus.iClearCount = 1'b0;
        repeat (3) step();
        chk("rst_valid", int'(bus.oValid), 0);
        chk("rst_x", int'(bus.oX_PIX), 0);
        chk("rst_y", int'(bus.oY_PIX), 0);
        chk("rst_press", int'(bus.oPress), 0);
        chk("rst_release", int'(bus.oRelease), 0);
        chk("rst_held", int'(bus.oHeld), 0);
        chk("rst_count", int'(bus.oPressCount), 0);
        rst_n = 1'b1;
        step();

        bus.iTouch = 1'b1;
        repeat (10) step();
        send_block(0, 0, 4095, 799, 0, 1'b1, 1'b0);
        chk("first_count", int'(bus.oPressCount), 1);
        chk("first_held", int'(bus.oHeld), 1);
        chk("first_press_ev", press_ev, 1);

        send_block(1000, 2, 1024, 603, 359, 1'b0, 1'b0);
        chk("second_count", int'(bus.oPressCount), 1);
        chk("second_press_ev", press_ev, 1);

        bus.iTouch = 1'b0;
        repeat (2) step();
        bus.iTouch = 1'b1;
        repeat (6) step();
        chk("bounce_rel_ev", rel_ev, 0);
        chk("bounce_held", int'(bus.oHeld), 1);
        send_block(2048, 0, 0, 399, 479, 1'b0, 1'b0);
        bus.iTouch = 1'b0;
        repeat (12) step();
        chk("release_ev", rel_ev, 1);
        chk("release_held", int'(bus.oHeld), 0);
        chk("release_count", int'(bus.oPressCount), 1);

        bus.iTouch = 1'b1;
        bus.iSample_valid = 1'b1;
        bus.iX_COORD = 12'd100;
        bus.iY_COORD = 12'd100;
        repeat (3) step();
        bus.iTouch = 1'b0;
        bus.iSample_valid = 1'b0;
        repeat (10) step();
        chk("glitch_valid_ev", valid_ev, 3);
        chk("glitch_press_ev", press_ev, 1);
        chk("glitch_held", int'(bus.oHeld), 0);

        bus.iTouch = 1'b1;
        repeat (10) step();
        bus.iSample_valid = 1'b1;
        bus.iX_COORD = 12'd500;
        repeat (2) step();
        bus.iSample_valid = 1'b0;
        bus.iTouch = 1'b0;
        repeat (12) step();
        chk("short_valid_ev", valid_ev, 3);
        chk("short_press_ev", press_ev, 1);
        chk("short_rel_ev", rel_ev, 1);
        chk("short_count", int'(bus.oPressCount), 1);

        for (int n = 0; n < 1022; n++) press_cycle(1'b0);
        chk("count_1023", int'(bus.oPressCount), 1023);
        chk("loop_press_ev", press_ev, 1023);
        chk("loop_rel_ev", rel_ev, 1023);
        press_cycle(1'b0);
        chk("count_wrap", int'(bus.oPressCount), 0);
        for (int n = 0; n < 1023; n++) press_cycle(1'b0);
        chk("count_1023_again", int'(bus.oPressCount), 1023);
        press_cycle(1'b1);
        chk("count_clear_inc", int'(bus.oPressCount), 1);

        bus.iTouch = 1'b1;
        repeat (9) step();
        send_block(0, 0, 4095, 799, 0, 1'b1, 1'b0);
        chk("pre_rst_held", int'(bus.oHeld), 1);
        chk("pre_rst_x", int'(bus.oX_PIX), 799);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.oValid), 0);
        chk("arst_x", int'(bus.oX_PIX), 0);
        chk("arst_y", int'(bus.oY_PIX), 0);
        chk("arst_press", int'(bus.oPress), 0);
        chk("arst_release", int'(bus.oRelease), 0);
        chk("arst_held", int'(bus.oHeld), 0);
        chk("arst_count", int'(bus.oPressCount), 0);
        bus.iTouch = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
